// File: rtl/view_seq_pkg.sv
// Shared definitions for the item viewer: FSM encoding, source-select codes
// and the index widths driven back to the CPU.
package view_seq_pkg;

    localparam int ITEM_W = 6;
    localparam int ARR_W  = 2;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SHOW   = 1'b1
    } state_t;

    localparam logic [1:0] SRC_ODATA = 2'd0;
    localparam logic [1:0] SRC_PC    = 2'd1;
    localparam logic [1:0] SRC_INST  = 2'd2;
    localparam logic [1:0] SRC_ITEM  = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce
    import view_seq_pkg::*;
#(
    parameter int DEB = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = cnt_w(DEB);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // level only moves after DEB consecutive synchronised samples disagree with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB - 1)) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/view_seq.sv
// Steps through CPU debug items (auto or by buttons), waits for the CPU to
// settle after each index change, then freezes one selected bus for display.
module view_seq
    import view_seq_pkg::*;
#(
    parameter int DWELL    = 50_000_000,
    parameter int SETTLE   = 64,
    parameter int DEB      = 1_000_000,
    parameter int ITEM_MAX = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              auto_en,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic [ARR_W-1:0]  array_sel,
    input  logic [1:0]        src_sel,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic [31:0]       odata,
    output logic [ARR_W-1:0]  array_choose,
    output logic [ITEM_W-1:0] item_choose,
    output logic [31:0]       disp_data,
    output logic              disp_valid,
    output state_t            dbg_state
);

    localparam int SW = cnt_w(SETTLE);
    localparam int DW = cnt_w(DWELL);

    // disp_valid is a plain level qualifier: no ready, the consumer samples
    // disp_data whenever disp_valid is high and the value stays frozen.

    logic pulse_next;
    logic pulse_prev;

    btn_debounce #(.DEB(DEB)) u_deb_next (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_next),
        .pulse (pulse_next)
    );

    btn_debounce #(.DEB(DEB)) u_deb_prev (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_prev),
        .pulse (pulse_prev)
    );

    state_t            state, state_n;
    logic [SW-1:0]     settle_cnt, settle_n;
    logic [DW-1:0]     dwell_cnt, dwell_n;
    logic [ITEM_W-1:0] item_n;
    logic [ARR_W-1:0]  arr_n;
    logic              arr_init, arr_init_n;
    logic [31:0]       data_n;
    logic              valid_n;
    logic [1:0]        cap_src, cap_src_n;
    logic              item_change;
    logic [ITEM_W-1:0] item_inc;
    logic [ITEM_W-1:0] item_dec;
    logic [31:0]       src_value;

    assign item_inc  = (item_choose == ITEM_W'(ITEM_MAX)) ? '0 : item_choose + ITEM_W'(1);
    assign item_dec  = (item_choose == '0) ? ITEM_W'(ITEM_MAX) : item_choose - ITEM_W'(1);
    assign dbg_state = state;

    always_comb begin
        src_value = odata;
        case (src_sel)
            SRC_ODATA: src_value = odata;
            SRC_PC:    src_value = pc;
            SRC_INST:  src_value = inst;
            SRC_ITEM:  src_value = {{(32-ITEM_W){1'b0}}, item_choose};
            default:   src_value = odata;
        endcase
    end

    always_comb begin
        state_n     = state;
        settle_n    = settle_cnt;
        dwell_n     = dwell_cnt;
        item_n      = item_choose;
        arr_n       = arr_init ? array_choose : array_sel;
        arr_init_n  = 1'b1;
        data_n      = disp_data;
        valid_n     = disp_valid;
        cap_src_n   = cap_src;
        item_change = 1'b0;

        // Coincident next/prev pulses cancel; a single button beats auto expiry.
        if (pulse_next && !pulse_prev) begin
            item_n      = item_inc;
            item_change = 1'b1;
        end else if (pulse_prev && !pulse_next) begin
            item_n      = item_dec;
            item_change = 1'b1;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        data_n    = src_value;
                        valid_n   = 1'b1;
                        cap_src_n = src_sel;
                        settle_n  = '0;
                        state_n   = ST_SHOW;
                    end else begin
                        settle_n = settle_cnt + SW'(1);
                    end
                end
                ST_SHOW: begin
                    if (array_sel != array_choose) begin
                        item_n      = '0;
                        item_change = 1'b1;
                    end else if (src_sel != cap_src) begin
                        state_n  = ST_SETTLE;
                        settle_n = '0;
                        dwell_n  = '0;
                        valid_n  = 1'b0;
                    end else if (auto_en) begin
                        if (dwell_cnt == DW'(DWELL - 1)) begin
                            item_n      = item_inc;
                            item_change = 1'b1;
                        end else begin
                            dwell_n = dwell_cnt + DW'(1);
                        end
                    end
                end
                default: state_n = ST_SETTLE;
            endcase
        end

        if (item_change) begin
            arr_n    = array_sel;
            state_n  = ST_SETTLE;
            settle_n = '0;
            dwell_n  = '0;
            valid_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_SETTLE;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
            item_choose  <= '0;
            array_choose <= '0;
            arr_init     <= 1'b0;
            disp_data    <= '0;
            disp_valid   <= 1'b0;
            cap_src      <= '0;
        end else begin
            state        <= state_n;
            settle_cnt   <= settle_n;
            dwell_cnt    <= dwell_n;
            item_choose  <= item_n;
            array_choose <= arr_n;
            arr_init     <= arr_init_n;
            disp_data    <= data_n;
            disp_valid   <= valid_n;
            cap_src      <= cap_src_n;
        end
    end

endmodule

// File: tb/tb_view_seq.sv
// Directed bench for view_seq with a per-cycle reference model and a few
// hand-computed checkpoints.
module tb_view_seq;
    import view_seq_pkg::*;

    localparam int DWELL    = 10;
    localparam int SETTLE   = 4;
    localparam int DEB      = 3;
    localparam int ITEM_MAX = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        auto_en = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic [1:0]  array_sel = 2'd0;
    logic [1:0]  src_sel = 2'd0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic [31:0] odata = '0;
    logic [1:0]  array_choose;
    logic [5:0]  item_choose;
    logic [31:0] disp_data;
    logic        disp_valid;
    state_t      dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    view_seq #(
        .DWELL(DWELL), .SETTLE(SETTLE), .DEB(DEB), .ITEM_MAX(ITEM_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .auto_en      (auto_en),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .array_sel    (array_sel),
        .src_sel      (src_sel),
        .pc           (pc),
        .inst         (inst),
        .odata        (odata),
        .array_choose (array_choose),
        .item_choose  (item_choose),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .dbg_state    (dbg_state)
    );

    // Reference model: time left to capture, elapsed dwell, and a sliding
    // window of raw button samples (two-sample synchroniser lag).
    logic [5:0]  m_item;
    logic [1:0]  m_arr;
    logic [31:0] m_data;
    logic        m_valid;
    logic [1:0]  m_cap_src;
    bit          m_arr_init;
    int          m_settle_left;
    int          m_dwell;
    bit          m_lvl_n, m_lvl_p, m_pn, m_pp;
    bit          hist_n[DEB+2];
    bit          hist_p[DEB+2];

    task automatic m_change(input logic [5:0] ni);
        m_item        = ni;
        m_arr         = array_sel;
        m_valid       = 1'b0;
        m_dwell       = 0;
        m_settle_left = SETTLE;
    endtask

    function automatic logic [5:0] m_inc(input logic [5:0] i);
        return (i == 6'(ITEM_MAX)) ? 6'd0 : i + 6'd1;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit pn, pp, diff_n, diff_p;
        if (!reset) begin
            m_item = '0; m_arr = '0; m_data = '0; m_valid = 1'b0; m_cap_src = '0;
            m_arr_init = 1'b0; m_settle_left = SETTLE; m_dwell = 0;
            m_lvl_n = 1'b0; m_lvl_p = 1'b0; m_pn = 1'b0; m_pp = 1'b0;
            for (int i = 0; i < DEB + 2; i++) begin
                hist_n[i] = 1'b0;
                hist_p[i] = 1'b0;
            end
        end else begin
            pn = m_pn;
            pp = m_pp;
            if (!m_arr_init) begin
                m_arr = array_sel;
                m_arr_init = 1'b1;
            end
            if (pn && !pp) m_change(m_inc(m_item));
            else if (pp && !pn) m_change((m_item == 6'd0) ? 6'(ITEM_MAX) : m_item - 6'd1);
            else if (m_settle_left == 0) begin
                if (array_sel != m_arr) m_change(6'd0);
                else if (src_sel != m_cap_src) begin
                    m_valid = 1'b0;
                    m_settle_left = SETTLE;
                    m_dwell = 0;
                end else if (auto_en) begin
                    m_dwell++;
                    if (m_dwell == DWELL) m_change(m_inc(m_item));
                end
            end else begin
                m_settle_left--;
                if (m_settle_left == 0) begin
                    m_valid = 1'b1;
                    m_cap_src = src_sel;
                    case (src_sel)
                        2'd0: m_data = odata;
                        2'd1: m_data = pc;
                        2'd2: m_data = inst;
                        default: m_data = {26'd0, m_item};
                    endcase
                end
            end
            for (int i = DEB + 1; i > 0; i--) begin
                hist_n[i] = hist_n[i-1];
                hist_p[i] = hist_p[i-1];
            end
            hist_n[0] = btn_next;
            hist_p[0] = btn_prev;
            diff_n = 1'b1;
            diff_p = 1'b1;
            for (int i = 2; i <= DEB + 1; i++) begin
                if (hist_n[i] == m_lvl_n) diff_n = 1'b0;
                if (hist_p[i] == m_lvl_p) diff_p = 1'b0;
            end
            m_pn = 1'b0;
            m_pp = 1'b0;
            if (diff_n) begin m_lvl_n = ~m_lvl_n; m_pn = m_lvl_n; end
            if (diff_p) begin m_lvl_p = ~m_lvl_p; m_pp = m_lvl_p; end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (item_choose !== m_item || array_choose !== m_arr ||
            disp_data !== m_data || disp_valid !== m_valid) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL cycle_model t=%0t item %0d want %0d arr %0d want %0d data %h want %h valid %b want %b",
                         $time, item_choose, m_item, array_choose, m_arr, disp_data, m_data, disp_valid, m_valid);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic press(input bit n, input bit p);
        btn_next = n;
        btn_prev = p;
        tick(6);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(8);
    endtask

    initial begin
        pc      = 32'h1234_5678;
        inst    = 32'h0000_0013;
        odata   = 32'hCAFE_0000;
        auto_en = 1'b1;
        src_sel = 2'd3;
        tick(3);
        lit("rst_item", 32'(item_choose), 32'd0);
        lit("rst_arr", 32'(array_choose), 32'd0);
        lit("rst_data", disp_data, 32'd0);
        lit("rst_valid", 32'(disp_valid), 32'd0);
        lit("rst_state", 32'(dbg_state), 32'(ST_SETTLE));

        reset = 1'b1;
        tick(4);
        lit("first_cap", disp_data, 32'd0);
        lit("first_valid", 32'(disp_valid), 32'd1);
        lit("first_state", 32'(dbg_state), 32'(ST_SHOW));
        for (int k = 1; k <= 4; k++) begin
            tick(10);
            lit("auto_step_valid", 32'(disp_valid), 32'd0);
            lit("auto_step_item", 32'(item_choose), 32'(k % 4));
            tick(4);
            lit("auto_cap", disp_data, 32'(k % 4));
        end

        auto_en  = 1'b0;
        btn_next = 1'b1;
        tick(5);
        lit("hold_pre", 32'(item_choose), 32'd0);
        tick(1);
        lit("hold_step", 32'(item_choose), 32'd1);
        tick(4);
        lit("hold_cap", disp_data, 32'd1);
        tick(10);
        btn_next = 1'b0;
        lit("hold_single", 32'(item_choose), 32'd1);
        tick(8);

        press(1'b0, 1'b1);
        lit("prev_1to0", 32'(item_choose), 32'd0);
        press(1'b0, 1'b1);
        lit("prev_wrap", 32'(item_choose), 32'd3);
        press(1'b1, 1'b0);
        lit("next_wrap", 32'(item_choose), 32'd0);
        press(1'b1, 1'b1);
        lit("both_cancel", 32'(item_choose), 32'd0);

        src_sel = 2'd1;
        tick(1);
        lit("src_resettle", 32'(disp_valid), 32'd0);
        tick(4);
        lit("src_pc_cap", disp_data, 32'h1234_5678);
        src_sel = 2'd3;
        tick(5);

        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        lit("arr_pre_item", 32'(item_choose), 32'd2);
        array_sel = 2'd2;
        tick(1);
        lit("arr_load", 32'(array_choose), 32'd2);
        lit("arr_item0", 32'(item_choose), 32'd0);
        tick(4);
        lit("arr_cap_valid", 32'(disp_valid), 32'd1);

        auto_en = 1'b1;
        tick(5);
        auto_en = 1'b0;
        tick(7);
        lit("freeze_item", 32'(item_choose), 32'd0);
        auto_en = 1'b1;
        tick(4);
        lit("resume_hold", 32'(item_choose), 32'd0);
        tick(1);
        lit("resume_step", 32'(item_choose), 32'd1);

        tick(2);
        reset = 1'b0;
        #1;
        lit("midrst_item", 32'(item_choose), 32'd0);
        lit("midrst_arr", 32'(array_choose), 32'd0);
        lit("midrst_data", disp_data, 32'd0);
        lit("midrst_valid", 32'(disp_valid), 32'd0);
        tick(2);
        reset   = 1'b1;
        src_sel = 2'd2;
        tick(1);
        lit("rel_arr_sample", 32'(array_choose), 32'd2);
        tick(3);
        lit("rel_cap_inst", disp_data, 32'h0000_0013);

        src_sel = 2'd0;
        for (int i = 0; i < 40; i++) begin
            odata = 32'hA5A5_0000 + 32'(i);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/view_seq.md
VIEW_SEQ -- requirements
Module: view_seq

Interface
REQ-001 Parameter DWELL, default 50_000_000, clk cycles each item is shown in auto mode (>=1).
REQ-002 Parameter SETTLE, default 64, clk cycles waited after an index change before capture (>=1; covers divided CPU clock).
REQ-003 Parameter DEB, default 1_000_000, clk cycles a button must be stable to register.
REQ-004 Parameter ITEM_MAX, default 63, last valid item index (0..63).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 auto_en  in  1  1 = auto-step items, 0 = manual stepping.
REQ-008 btn_next  in  1  raw push button, advance item.
REQ-009 btn_prev  in  1  raw push button, retreat item.
REQ-010 array_sel  in  2  requested memory array; applied at next item change.
REQ-011 src_sel  in  2  0 = odata, 1 = pc, 2 = inst, 3 = {26'b0, item index}.
REQ-012 pc, inst, odata  in  32 each  CPU debug buses.
REQ-013 array_choose  out  2  array index driven to CPU.
REQ-014 item_choose  out  6  item index driven to CPU.
REQ-015 disp_data  out  32  frozen value for seg7x16.
REQ-016 disp_valid  out  1  1 while disp_data holds a capture for current index.

Function
REQ-017 FSM states: SETTLE, SHOW; reset state SETTLE with settle counter cleared.
REQ-018 SETTLE: count SETTLE cycles; on final cycle capture selected source into disp_data, set disp_valid, go SHOW.
REQ-019 SHOW: disp_data held constant; dwell counter increments only when auto_en=1.
REQ-020 Auto step: when dwell counter reaches DWELL-1, item advances, dwell clears, disp_valid clears, go SETTLE.
REQ-021 Manual step: a debounced rising edge of btn_next/btn_prev in any state advances/retreats item, clears dwell and settle counters, clears disp_valid, enters SETTLE.
REQ-022 Debounce: each button has own counter; registered level changes only after DEB consecutive stable samples; one step per press regardless of hold length.
REQ-023 Simultaneous debounced edges of next and prev in same cycle: no step, no state change.
REQ-024 Manual edge coincident with auto expiry: one step only, direction of the button.
REQ-025 Wrap: next at ITEM_MAX -> 0; prev at 0 -> ITEM_MAX; auto follows next rule.
REQ-026 array_choose loads array_sel on every item change and at reset release; when array_sel differs from array_choose during SHOW, item resets to 0 and FSM enters SETTLE.
REQ-027 src_sel change during SHOW: forces re-entry to SETTLE without item change.
REQ-028 auto_en falling mid-dwell: dwell counter frozen, resumes from held value on auto_en rising.
REQ-029 All outputs registered; item_choose changes exactly one cycle after triggering event; disp_data updates exactly SETTLE cycles after item change.

Reset
REQ-030 On reset low: item_choose=0, array_choose=0, disp_data=0, disp_valid=0, all counters 0, debounced levels 0, FSM=SETTLE.
REQ-031 Reset asserted mid-operation aborts any dwell/settle immediately; first capture after release occurs SETTLE cycles later.
REQ-032 array_sel sampled on first clock edge after reset release.

Structure
REQ-033 Shared package holds FSM state encoding, src_sel codes, and ITEM_W=6 / ARR_W=2 width constants.
REQ-034 One sub-module btn_debounce (parameter DEB; ports clk, reset, raw, pulse) instantiated twice.
REQ-035 view_seq sits between static_cpu and seg7x16 in the top; no combinational path from pc/inst/odata to disp_data.

Verification (DWELL=10, SETTLE=4, DEB=3, ITEM_MAX=3)
REQ-036 Reset release, auto_en=1, src_sel=3 -> disp_data 0,1,2,3,0 every 14 cycles; disp_valid low 4 cycles per step.
REQ-037 auto_en=0, btn_next held 20 cycles -> single step 0->1, captured 4 cycles after item change.
REQ-038 item=0, btn_prev pulse (>=3 cycles) -> item_choose=3; btn_next and btn_prev edges same cycle -> item unchanged.
REQ-039 array_sel 0->2 during SHOW at item 2 -> array_choose=2, item_choose=0, new capture 4 cycles later.
REQ-040 reset pulsed low during SETTLE -> all outputs 0 immediately, normal sequence restarts after release.
